// File: rtl/latex_pair_streamer.sv
// latex_pair_streamer: streams one table line as two lockstep ASCII channels.
// The lhs channel is the time-domain function and the rhs channel its Laplace
// transform, both as LaTeX text. The streamer looks up the line's base address
// and length in the line mapper, fetches packed words from the char ROM and
// emits one char pair per valid/ready beat. The shorter side is padded with
// spaces.
// Optional build macro CQ_BEACON_EN: an accepted start with beacon=1 streams the
// constant "CQ DE KC1GPW" on both channels without touching the mapper or ROM.
module latex_pair_streamer #(
  parameter int LINE_W    = 6,
  parameter int NUM_LINES = 51,
  parameter int ADDR_W    = 10,
  parameter int CPW       = 2,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LINE_W-1:0] line,
  input  logic              beacon,
  output logic [LINE_W-1:0] map_line,
  input  logic [ADDR_W-1:0] map_lhs_base,
  input  logic [ADDR_W-1:0] map_rhs_base,
  input  logic [CNT_W-1:0]  map_lhs_len,
  input  logic [CNT_W-1:0]  map_rhs_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [8*CPW-1:0]  mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        lhs_char,
  output logic [7:0]        rhs_char,
  output logic [CNT_W-1:0]  chars_remaining,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WORD_W = 8 * CPW;
  localparam int K_W    = (CPW > 1) ? $clog2(CPW) : 1;
  localparam logic [WORD_W-1:0] SPACES = {CPW{8'h20}};

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_FETCH_L, S_FETCH_R, S_EMIT, S_DONE
  } state_t;

  state_t            state, state_next;
  logic              start_q;
  logic              ph;          // second cycle of a two-cycle MAP/FETCH step
  logic [LINE_W-1:0] line_r;
  logic              err_r;
  logic [ADDR_W-1:0] lhs_addr, rhs_addr;
  logic [CNT_W-1:0]  lhs_left, rhs_left, rem;
  logic [K_W-1:0]    k;
  logic [WORD_W-1:0] lhs_word, rhs_word;
  logic              bcn;
  logic              accept, bad_line, fire, k_wrap;
  logic [CNT_W-1:0]  total;

  // Byte kk of a packed word, char 0 in the most significant byte.
  function automatic logic [7:0] pick(input logic [WORD_W-1:0] w, input logic [K_W-1:0] kk);
    logic [WORD_W-1:0] t;
    t = w << (8 * kk);
    return t[WORD_W-1 -: 8];
  endfunction

`ifdef CQ_BEACON_EN
  logic beacon_r;

  function automatic logic [7:0] cq_char(input logic [CNT_W-1:0] i);
    case (i)
      0: return "C";  1: return "Q";  2: return " ";  3: return "D";
      4: return "E";  5: return " ";  6: return "K";  7: return "C";
      8: return "1";  9: return "G"; 10: return "P"; 11: return "W";
      default: return 8'h20;
    endcase
  endfunction

  // Beacon mode flag, sampled with the accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beacon_r <= 1'b0;
    else if (accept) beacon_r <= beacon;
  end

  assign bcn = beacon_r;
`else
  logic beacon_unused;
  assign beacon_unused = beacon;
  assign bcn = 1'b0;
`endif

  assign accept   = start && !start_q && (state == S_IDLE);
  assign bad_line = !bcn && ({1'b0, line_r} >= (LINE_W+1)'(NUM_LINES));
  assign fire     = (state == S_EMIT) && out_ready;
  assign k_wrap   = (k == K_W'(CPW - 1));
  assign total    = bcn ? CNT_W'(12)
                  : ((map_lhs_len > map_rhs_len) ? map_lhs_len : map_rhs_len);

  assign map_line        = line_r;
  assign chars_remaining = rem;
  assign err             = err_r;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = S_MAP;
      S_MAP: begin
        if (!ph) begin
          if (bad_line) state_next = S_DONE;
        end else begin
          state_next = (total == '0) ? S_DONE : S_FETCH_L;
        end
      end
      S_FETCH_L: if (ph) state_next = S_FETCH_R;
      S_FETCH_R: if (ph) state_next = S_EMIT;
      S_EMIT: begin
        if (fire) begin
          if (rem == CNT_W'(1)) state_next = S_DONE;
          else if (k_wrap)      state_next = S_FETCH_L;
        end
      end
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode; ROM address and chars are driven only when meaningful.
  always_comb begin
    out_valid = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    lhs_char  = 8'h00;
    rhs_char  = 8'h00;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    case (state)
      S_FETCH_L: if (!ph && !bcn && lhs_left != '0) begin
        mem_rd   = 1'b1;
        mem_addr = lhs_addr;
      end
      S_FETCH_R: if (!ph && !bcn && rhs_left != '0) begin
        mem_rd   = 1'b1;
        mem_addr = rhs_addr;
      end
      S_EMIT: begin
        out_valid = 1'b1;
`ifdef CQ_BEACON_EN
        if (bcn) begin
          lhs_char = cq_char(CNT_W'(12) - rem);
          rhs_char = cq_char(CNT_W'(12) - rem);
        end else
`endif
        begin
          lhs_char = (lhs_left != '0) ? pick(lhs_word, k) : 8'h20;
          rhs_char = (rhs_left != '0) ? pick(rhs_word, k) : 8'h20;
        end
      end
      default: ;
    endcase
  end

  // Datapath: start edge detect, line capture, mapper latch, word buffers, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      ph       <= 1'b0;
      line_r   <= '0;
      err_r    <= 1'b0;
      lhs_addr <= '0;
      rhs_addr <= '0;
      lhs_left <= '0;
      rhs_left <= '0;
      rem      <= '0;
      k        <= '0;
      lhs_word <= '0;
      rhs_word <= '0;
    end else begin
      start_q <= start;
      ph      <= (state == S_MAP || state == S_FETCH_L || state == S_FETCH_R) ? !ph : 1'b0;
      if (accept) begin
        line_r <= line;
        err_r  <= 1'b0;
      end
      case (state)
        S_MAP: begin
          if (!ph) begin
            if (bad_line) err_r <= 1'b1;
          end else begin
            lhs_addr <= map_lhs_base;
            rhs_addr <= map_rhs_base;
            lhs_left <= map_lhs_len;
            rhs_left <= map_rhs_len;
            rem      <= total;
            k        <= '0;
          end
        end
        S_FETCH_L: if (ph) lhs_word <= (!bcn && lhs_left != '0) ? mem_dout : SPACES;
        S_FETCH_R: if (ph) rhs_word <= (!bcn && rhs_left != '0) ? mem_dout : SPACES;
        S_EMIT: if (fire) begin
          rem <= rem - CNT_W'(1);
          if (lhs_left != '0) lhs_left <= lhs_left - CNT_W'(1);
          if (rhs_left != '0) rhs_left <= rhs_left - CNT_W'(1);
          if (k_wrap) begin
            k        <= '0;
            lhs_addr <= lhs_addr + ADDR_W'(1);
            rhs_addr <= rhs_addr + ADDR_W'(1);
          end else begin
            k <= k + K_W'(1);
          end
        end
        S_DONE: rem <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_latex_pair_streamer.sv
// Directed bench for latex_pair_streamer: a registered line-mapper model and a
// char ROM model feed the DUT; every beat is compared against hand-written
// expected strings.
module tb_latex_pair_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  line = '0;
  logic        beacon = 1'b0;
  logic [5:0]  map_line;
  logic [9:0]  map_lhs_base = '0, map_rhs_base = '0;
  logic [9:0]  map_lhs_len = '0, map_rhs_len = '0;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  lhs_char, rhs_char;
  logic [9:0]  chars_remaining;
  logic        busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int rd_count = 0;
  int last_done_cyc = -1;
  logic [15:0] rom [1024];

  latex_pair_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line(line), .beacon(beacon),
    .map_line(map_line), .map_lhs_base(map_lhs_base), .map_rhs_base(map_rhs_base),
    .map_lhs_len(map_lhs_len), .map_rhs_len(map_rhs_len),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .lhs_char(lhs_char), .rhs_char(rhs_char), .chars_remaining(chars_remaining),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Line mapper model: one-cycle registered lookup.
  always @(posedge clk) begin
    case (map_line)
      6'd3: begin
        map_lhs_base <= 10'd10;   map_lhs_len <= 10'd3;
        map_rhs_base <= 10'd20;   map_rhs_len <= 10'd9;
      end
      6'd7: begin
        map_lhs_base <= 10'd1023; map_lhs_len <= 10'd4;
        map_rhs_base <= 10'd40;   map_rhs_len <= 10'd1;
      end
      default: begin
        map_lhs_base <= 10'd0;    map_lhs_len <= 10'd0;
        map_rhs_base <= 10'd0;    map_rhs_len <= 10'd0;
      end
    endcase
  end

  // Char ROM model: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_dout <= rom[mem_addr];
      rd_count <= rd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer: start edge, collect beats, check done/idle.
  task automatic run(input string tag, input logic [5:0] ln, input logic bcn,
                     input bit toggle, input bit hold, input int poke,
                     input int n, input string el, input string er);
    int beats = 0;
    int cyc = 1;
    int first = -1;
    bit seen = 1'b0;
    bit poked = 1'b0;
    @(negedge clk);
    line = ln; beacon = bcn; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    beacon = 1'b0;
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    check({tag, "_err_cleared"}, {31'd0, err}, 32'd0);
    out_ready = 1'b0;
    while (!seen && cyc < 300) begin
      if (poked && !hold) start = 1'b0;
      if (poke >= 0 && !poked && beats == poke) begin
        start = 1'b1;
        poked = 1'b1;
      end
      out_ready = toggle ? ~out_ready : 1'b1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (beats < n) begin
          check($sformatf("%s_lhs%0d", tag, beats), {24'd0, lhs_char}, {24'd0, el.getc(beats)});
          check($sformatf("%s_rhs%0d", tag, beats), {24'd0, rhs_char}, {24'd0, er.getc(beats)});
          check($sformatf("%s_rem%0d", tag, beats), {22'd0, chars_remaining}, n - beats);
        end else begin
          check({tag, "_extra_beat"}, {31'd0, out_valid}, 32'd0);
        end
        if (out_ready) beats++;
      end
      if (done) begin
        seen = 1'b1;
        last_done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    if (!hold) start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_beats"}, beats, n);
    if (n > 0) check({tag, "_latency_ge5"}, {31'd0, first >= 5}, 32'd1);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_rem_end"}, {22'd0, chars_remaining}, 32'd0);
    check({tag, "_valid_end"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int rd0;
    int busy_cycles;
    int b;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h5A5A;  // "ZZ" filler
    rom[10] = "t^";  rom[11] = "2Z";
    rom[20] = "\\f"; rom[21] = "ra"; rom[22] = "c{"; rom[23] = "2}"; rom[24] = "{Z";
    rom[1023] = "e^"; rom[0] = "-t";
    rom[40] = "1Z";   rom[41] = "QQ";

    // Outputs while reset is held.
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_rem",   {22'd0, chars_remaining}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    #20;
    rst_n = 1'b1;

    // Line 3, consumer always ready.
    run("l3", 6'd3, 1'b0, 1'b0, 1'b0, -1, 9, "t^2      ", "\\frac{2}{");

    // Line 3 with ready toggling: same sequence, held while ready is low.
    run("l3_tog", 6'd3, 1'b0, 1'b1, 1'b0, -1, 9, "t^2      ", "\\frac{2}{");

    // Line 7: lhs longer than rhs, lhs word address wraps 1023 -> 0.
    run("l7", 6'd7, 1'b0, 1'b0, 1'b0, -1, 4, "e^-t", "1   ");

    // Line 5 has zero length on both sides: no beats, no ROM reads.
    rd0 = rd_count;
    run("l5", 6'd5, 1'b0, 1'b0, 1'b0, -1, 0, "", "");
    check("l5_no_reads", rd_count - rd0, 32'd0);

    // Bad line: err set, no beats, done two cycles after the start edge.
    run("bad", 6'd60, 1'b0, 1'b0, 1'b0, -1, 0, "", "");
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_done_cyc", last_done_cyc, 32'd2);
    // A valid start clears err (checked inside run) and it stays clear.
    run("after_bad", 6'd3, 1'b0, 1'b0, 1'b0, -1, 9, "t^2      ", "\\frac{2}{");
    check("after_bad_err", {31'd0, err}, 32'd0);

    // Reset during the 4th beat aborts at once; a fresh start replays from beat 1.
    @(negedge clk);
    line = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    b = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin
        if (b == 3) break;
        b++;
      end
      @(negedge clk);
    end
    check("rst4_reached", b, 32'd3);
    check("rst4_rem_before", {22'd0, chars_remaining}, 32'd6);
    rst_n = 1'b0;
    #1;
    check("rst4_valid", {31'd0, out_valid}, 32'd0);
    check("rst4_busy",  {31'd0, busy}, 32'd0);
    check("rst4_rem",   {22'd0, chars_remaining}, 32'd0);
    check("rst4_done",  {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("replay", 6'd3, 1'b0, 1'b0, 1'b0, -1, 9, "t^2      ", "\\frac{2}{");

    // Start held high: exactly one transfer, no retrigger over 100 cycles.
    run("hold", 6'd3, 1'b0, 1'b0, 1'b1, -1, 9, "t^2      ", "\\frac{2}{");
    busy_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("hold_no_retrigger", busy_cycles, 32'd0);
    start = 1'b0;

    // A fresh start edge while busy is ignored.
    run("poke", 6'd3, 1'b0, 1'b0, 1'b0, 2, 9, "t^2      ", "\\frac{2}{");
    busy_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("poke_ignored", busy_cycles, 32'd0);

`ifdef CQ_BEACON_EN
    // Beacon: constant text on both channels, ROM untouched.
    rd0 = rd_count;
    run("beacon", 6'd60, 1'b1, 1'b0, 1'b0, -1, 12, "CQ DE KC1GPW", "CQ DE KC1GPW");
    check("beacon_no_reads", rd_count - rd0, 32'd0);
    check("beacon_no_err", {31'd0, err}, 32'd0);
`else
    // Without the beacon feature the beacon input is ignored.
    run("beacon_off", 6'd3, 1'b1, 1'b0, 1'b0, -1, 9, "t^2      ", "\\frac{2}{");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
